dm_bus_arbiter: RTL and testbench
=================================

Name: dm_bus_arbiter

Overview:
- Shares the single CPU-side port of the memory/peripheral bridge between two masters: the M-stage load/store unit and a word-burst DMA copy engine.
- Arbitrates per transaction with round-robin fairness.
- Sequences DMA bursts by generating the beat addresses itself.
- Stalls the pipeline while the DMA owns the port.
- Sits between the M stage/DMA engine and the bridge; the bridge's decode and exception logic are unchanged.

Parameters:
MAX_BURST, 16, maximum DMA beats per burst; a burst length field of 0 encodes MAX_BURST
BLEN_W, 4, width of dma_burst_len; equals log2(MAX_BURST)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous reset, active low
cpu_req  input  1  M stage has a load/store this cycle
cpu_addr  input  32  CPU byte address
cpu_wdata  input  32  CPU store data
cpu_byteen  input  4  CPU store byte enables; 0 for loads
cpu_rdata  output  32  load data to M stage, combinational from bus_rdata
cpu_stall  output  1  freeze F/D/E/M; M instruction retries next cycle
dma_req  input  1  DMA requests a burst
dma_base  input  32  word-aligned burst start address
dma_burst_len  input  BLEN_W  beats; 0 means MAX_BURST
dma_we  input  1  1 = write burst, 0 = read burst
dma_wdata  input  32  write data for the current beat
dma_beat  output  1  current beat accepted this cycle
dma_rvalid  output  1  registered read data valid, one cycle after a read beat
dma_rdata  output  32  registered read data
dma_done  output  1  one-cycle pulse, registered, after the last beat
bus_addr  output  32  address to the bridge
bus_wdata  output  32  write data to the bridge
bus_byteen  output  4  byte enables to the bridge
bus_rdata  input  32  bridge read data, combinational

Behaviour:
- States: IDLE, DMA_BURST. CPU accesses never leave IDLE; they are single-cycle and combinational through the arbiter.
- IDLE, cpu_req only: CPU drives the bus, cpu_stall=0.
- IDLE, dma_req only:
  - Latch dma_base, burst length and dma_we; set beat_cnt=0.
  - Go to DMA_BURST next cycle. No beat is issued in the grant cycle.
- IDLE, both requesting: grant the master that is not last_owner.
  - last_owner resets to DMA, so the CPU wins the first conflict.
  - If the DMA wins, cpu_stall=1 in that cycle.
- DMA_BURST:
  - bus_addr = latched base + 4*beat_cnt.
  - bus_byteen = dma_we ? 4'hF : 4'h0.
  - dma_beat=1 every cycle; beat_cnt increments.
  - cpu_stall = cpu_req.
  - On the last beat (beat_cnt == len-1): return to IDLE, set last_owner=DMA, and pulse dma_done the next cycle.
- Address arithmetic is 32-bit modulo; crossing 0xFFFFFFFC wraps with no error.
- dma_req and its fields are ignored after the grant. Deasserting dma_req mid-burst does not abort the burst.
- Read beats: dma_rdata <= bus_rdata and dma_rvalid <= 1 on each read beat; otherwise dma_rvalid <= 0.
- A CPU grant sets last_owner=CPU.
- When the bus is unowned, bus_byteen=0, and bus_addr/bus_wdata follow the CPU inputs.
- Reset, including mid-burst: state=IDLE, beat_cnt=0, last_owner=DMA, and all registered outputs are 0: dma_rvalid, dma_rdata, dma_done. cpu_stall and dma_beat are 0 in IDLE.
  - The in-flight burst is dropped; the DMA must re-request.

Optional Feature:
ARB_CPU_PREEMPT_EN
- Defined:
  - In DMA_BURST, a cpu_req takes the bus for that cycle: the CPU is not stalled, dma_beat=0 and beat_cnt holds.
  - The burst resumes on the next cycle without cpu_req.
  - Consecutive CPU requests may starve the DMA indefinitely.
- Undefined: bursts are atomic as described in Behaviour.

Decomposition:
- Shared package holds:
  - state encodings ST_IDLE/ST_DMA
  - owner encodings OWN_CPU/OWN_DMA
  - MAX_BURST default
  - the word-stride constant 4
- One natural sub-module: dm_burst_addr_gen. It contains the base/length latch, the beat counter and the last-beat flag.
- Arbitration and output muxing stay in the top module.

Test Plan:
- Reset, then cpu_req=1 with dma_req=0, cpu_addr=0x100: bus_addr=0x100, cpu_stall=0, no DMA activity.
- dma_req with base 0x2000, len=3, read: grant cycle, then 3 beats at 0x2000/0x2004/0x2008; dma_rvalid one cycle after each beat; dma_done pulses once, the cycle after the last beat.
- cpu_req and dma_req simultaneously right after reset: CPU wins. Repeat the conflict: DMA wins, cpu_stall=1 for the grant cycle plus all len cycles.
- len=0 write burst from 0xFFFFFFF8: 16 beats. Addresses wrap 0xFFFFFFF8, 0xFFFFFFFC, 0x0, … 0x34, and bus_byteen=0xF on each beat.
- Assert rst_n=0 at beat 2 of a 5-beat burst: state returns to IDLE asynchronously, all outputs are 0, and a new dma_req restarts from the new base.
- With ARB_CPU_PREEMPT_EN defined, a cpu_req pulse at beat 1 of a len=4 burst: the CPU gets the bus with stall=0, dma_beat=0 that cycle, and 4 beats still complete in order.

Source files
------------

// File: rtl/dm_bus_arbiter_pkg.sv
// Shared encodings and constants for the CPU/DMA bus arbiter.
package dm_bus_arbiter_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_DMA  = 1'b1;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam int MAX_BURST_DEF = 16;

  localparam logic [31:0] WORD_STRIDE = 32'd4;

endpackage

// File: rtl/dm_burst_addr_gen.sv
// DMA burst sequencer: latches base/length/direction at grant and walks the
// word-stride beat addresses, flagging the final beat.
module dm_burst_addr_gen
  import dm_bus_arbiter_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int BLEN_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [31:0]       base,
  input  logic [BLEN_W-1:0] len,
  input  logic              we,
  input  logic              advance,
  output logic [31:0]       beat_addr,
  output logic              last_beat,
  output logic              burst_we
);

  localparam logic [BLEN_W:0] MAX_LEN = (BLEN_W + 1)'(MAX_BURST);

  logic [31:0]       base_q;
  logic [BLEN_W-1:0] len_q;
  logic              we_q;
  logic [BLEN_W-1:0] beat_cnt;
  logic [BLEN_W:0]   len_full;
  logic [BLEN_W:0]   cnt_next;

  // A zero length field stands for a full MAX_BURST burst.
  assign len_full  = (len_q == '0) ? MAX_LEN : {1'b0, len_q};
  assign cnt_next  = {1'b0, beat_cnt} + 1'b1;
  assign last_beat = (cnt_next == len_full);
  assign beat_addr = base_q + WORD_STRIDE * {{(32 - BLEN_W){1'b0}}, beat_cnt};
  assign burst_we  = we_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      len_q    <= '0;
      we_q     <= 1'b0;
      beat_cnt <= '0;
    end else if (load) begin
      base_q   <= base;
      len_q    <= len;
      we_q     <= we;
      beat_cnt <= '0;
    end else if (advance) begin
      beat_cnt <= last_beat ? '0 : cnt_next[BLEN_W-1:0];
    end
  end

endmodule

// File: rtl/dm_bus_arbiter.sv
// Round-robin arbiter sharing the bridge port between the M-stage LSU and the
// burst DMA engine. Define ARB_CPU_PREEMPT_EN to let CPU accesses interrupt bursts.
module dm_bus_arbiter
  import dm_bus_arbiter_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int BLEN_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_byteen,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic [31:0]       dma_base,
  input  logic [BLEN_W-1:0] dma_burst_len,
  input  logic              dma_we,
  input  logic [31:0]       dma_wdata,
  output logic              dma_beat,
  output logic              dma_rvalid,
  output logic [31:0]       dma_rdata,
  output logic              dma_done,
  output logic [31:0]       bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_byteen,
  input  logic [31:0]       bus_rdata
);

  logic        state;
  logic        last_owner;
  logic        grant_dma;
  logic        grant_cpu;
  logic        cpu_preempt;
  logic [31:0] beat_addr;
  logic        last_beat;
  logic        burst_we;

  dm_burst_addr_gen #(
    .MAX_BURST (MAX_BURST),
    .BLEN_W    (BLEN_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (grant_dma),
    .base      (dma_base),
    .len       (dma_burst_len),
    .we        (dma_we),
    .advance   (dma_beat),
    .beat_addr (beat_addr),
    .last_beat (last_beat),
    .burst_we  (burst_we)
  );

`ifdef ARB_CPU_PREEMPT_EN
  assign cpu_preempt = (state == ST_DMA) && cpu_req;
`else
  assign cpu_preempt = 1'b0;
`endif

  assign cpu_rdata = bus_rdata;

  // Grant decision and bus mux; CPU accesses pass straight through in one cycle.
  always_comb begin
    grant_dma  = 1'b0;
    grant_cpu  = 1'b0;
    dma_beat   = 1'b0;
    cpu_stall  = 1'b0;
    bus_addr   = cpu_addr;
    bus_wdata  = cpu_wdata;
    bus_byteen = 4'h0;
    if (state == ST_IDLE) begin
      grant_dma = dma_req && (!cpu_req || (last_owner == OWN_CPU));
      grant_cpu = cpu_req && !grant_dma;
      cpu_stall = cpu_req && grant_dma;
      if (grant_cpu) bus_byteen = cpu_byteen;
    end else if (cpu_preempt) begin
      grant_cpu  = 1'b1;
      bus_byteen = cpu_byteen;
    end else begin
      dma_beat   = 1'b1;
      cpu_stall  = cpu_req;
      bus_addr   = beat_addr;
      bus_wdata  = dma_wdata;
      bus_byteen = burst_we ? 4'hF : 4'h0;
    end
  end

  // Registered state, ownership history and DMA read return path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_owner <= OWN_DMA;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
      dma_done   <= 1'b0;
    end else begin
      if (state == ST_IDLE && grant_dma) state <= ST_DMA;
      else if (dma_beat && last_beat)   state <= ST_IDLE;

      if (dma_beat && last_beat) last_owner <= OWN_DMA;
      else if (grant_cpu)        last_owner <= OWN_CPU;

      dma_rvalid <= dma_beat && !burst_we;
      if (dma_beat && !burst_we) dma_rdata <= bus_rdata;
      dma_done <= dma_beat && last_beat;
    end
  end

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Randomized bench for dm_bus_arbiter against a transaction-level reference model.
module tb_dm_bus_arbiter;

  localparam int MAXB = 16;
`ifdef ARB_CPU_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_byteen;
  logic        cpu_stall;
  logic        dma_req;
  logic [31:0] dma_base;
  logic [3:0]  dma_burst_len;
  logic        dma_we;
  logic [31:0] dma_wdata;
  logic        dma_beat, dma_rvalid, dma_done;
  logic [31:0] dma_rdata;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_byteen;

  always #5 clk = ~clk;

  dm_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_byteen(cpu_byteen), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_base(dma_base), .dma_burst_len(dma_burst_len),
    .dma_we(dma_we), .dma_wdata(dma_wdata), .dma_beat(dma_beat),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_done(dma_done),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_byteen(bus_byteen),
    .bus_rdata(bus_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: a burst is "remaining beats + next address"; ownership is
  // just whether the DMA was the last one to finish using the bus.
  bit          m_busy;
  int          m_rem;
  logic [31:0] m_addr;
  bit          m_we;
  bit          m_last_dma;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        m_done;
  int          beats_seen, done_seen;

  task automatic model_reset();
    m_busy = 0; m_rem = 0; m_addr = '0; m_we = 0; m_last_dma = 1;
    m_rvalid = 0; m_rdata = '0; m_done = 0;
  endtask

  task automatic step();
    bit dma_wins, cpu_own, beat;
    logic [3:0] e_be;
    @(negedge clk);
    dma_wins = 0; cpu_own = 0; beat = 0;
    if (!m_busy) begin
      dma_wins = dma_req && (!cpu_req || !m_last_dma);
      cpu_own  = cpu_req && !dma_wins;
    end else if (PREEMPT && cpu_req) begin
      cpu_own = 1;
    end else begin
      beat = 1;
    end
    e_be = beat ? (m_we ? 4'hF : 4'h0) : (cpu_own ? cpu_byteen : 4'h0);
    chk("stall",  cpu_stall, cpu_req && !cpu_own);
    chk("beat",   dma_beat, beat);
    chk("addr",   bus_addr, beat ? m_addr : cpu_addr);
    chk("wdata",  bus_wdata, beat ? dma_wdata : cpu_wdata);
    chk("byteen", bus_byteen, e_be);
    chk("cpu_rdata", cpu_rdata, bus_rdata);
    chk("rvalid", dma_rvalid, m_rvalid);
    chk("rdata",  dma_rdata, m_rdata);
    chk("done",   dma_done, m_done);
    @(posedge clk);
    m_done   = beat && (m_rem == 1);
    m_rvalid = beat && !m_we;
    if (beat && !m_we) m_rdata = bus_rdata;
    if (beat) begin
      beats_seen++;
      m_addr = m_addr + 32'd4;
      m_rem--;
      if (m_rem == 0) begin m_busy = 0; m_last_dma = 1; end
    end else if (dma_wins) begin
      m_busy = 1;
      m_rem  = (dma_burst_len == 0) ? MAXB : int'(dma_burst_len);
      m_addr = dma_base;
      m_we   = dma_we;
    end
    if (cpu_own) m_last_dma = 0;
    if (m_done) done_seen++;
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_addr = '0; cpu_wdata = '0; cpu_byteen = '0;
    dma_req = 0; dma_base = '0; dma_burst_len = '0; dma_we = 0; dma_wdata = '0;
    bus_rdata = $urandom;
  endtask

  task automatic do_reset();
    cpu_req = 0; dma_req = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_beat",   dma_beat, 1'b0);
    chk("rst_stall",  cpu_stall, 1'b0);
    chk("rst_rvalid", dma_rvalid, 1'b0);
    chk("rst_rdata",  dma_rdata, 32'h0);
    chk("rst_done",   dma_done, 1'b0);
    chk("rst_byteen", bus_byteen, 4'h0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic start_dma(input logic [31:0] base, input logic [3:0] len, input logic we);
    dma_req = 1; dma_base = base; dma_burst_len = len; dma_we = we;
  endtask

  int b0, d0;

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    #2;
    do_reset();

    // Plain CPU access.
    cpu_req = 1; cpu_addr = 32'h100; cpu_wdata = 32'h1234_5678;
    step();
    cpu_req = 0;
    step();

    // Three-beat read burst.
    b0 = beats_seen; d0 = done_seen;
    start_dma(32'h2000, 4'd3, 1'b0);
    step();
    dma_req = 0;
    for (int i = 0; i < 5; i++) begin bus_rdata = $urandom; step(); end
    chk("rd3_beats", beats_seen - b0, 3);
    chk("rd3_done",  done_seen - d0, 1);

    // Conflicts: CPU wins first, then DMA.
    do_reset();
    cpu_req = 1; cpu_addr = 32'h40; cpu_byteen = 4'h3;
    start_dma(32'h500, 4'd2, 1'b0);
    step();
    chk("conf_owner_cpu", m_busy, 1'b0);
    step();
    chk("conf_owner_dma", m_busy, 1'b1);
    dma_req = 0;
    for (int i = 0; i < 4; i++) begin bus_rdata = $urandom; step(); end
    cpu_req = 0;
    for (int i = 0; i < 3; i++) step();

    // Full-length write burst wrapping past the top of the address space.
    b0 = beats_seen;
    start_dma(32'hFFFF_FFF8, 4'd0, 1'b1);
    step();
    dma_req = 0;
    for (int i = 0; i < 18; i++) begin dma_wdata = $urandom; step(); end
    chk("wrap_beats", beats_seen - b0, 16);

    // Reset in the middle of a five-beat burst, then restart elsewhere.
    start_dma(32'h3000, 4'd5, 1'b0);
    step();
    dma_req = 0;
    step(); step();
    do_reset();
    b0 = beats_seen;
    start_dma(32'h4000, 4'd2, 1'b0);
    step();
    dma_req = 0;
    for (int i = 0; i < 4; i++) step();
    chk("restart_beats", beats_seen - b0, 2);

    // CPU pulse during beat 1 of a four-beat burst.
    b0 = beats_seen;
    start_dma(32'h6000, 4'd4, 1'b1);
    step();
    dma_req = 0;
    step();
    cpu_req = 1; cpu_addr = 32'h80; cpu_byteen = 4'hF;
    step();
    cpu_req = 0; cpu_byteen = 4'h0;
    for (int i = 0; i < 6; i++) step();
    chk("pre_beats", beats_seen - b0, 4);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cpu_req    = $urandom_range(0, 1);
      cpu_addr   = $urandom;
      cpu_wdata  = $urandom;
      cpu_byteen = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      dma_req    = ($urandom_range(0, 3) == 0);
      dma_base   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFC0 | (32'($urandom) & 32'h3C))
                                               : (32'($urandom) & ~32'h3);
      dma_burst_len = 4'($urandom);
      dma_we     = $urandom_range(0, 1);
      dma_wdata  = $urandom;
      bus_rdata  = $urandom;
      if ($urandom_range(0, 599) == 0) do_reset();
      else step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
